uart_rx_ctrl: RTL and testbench

UART receiver for the video transport link's serial control channel, and the peer of the existing UART transmit controller. It oversamples the serial line with the system clock and recovers one 8N1 frame at a time: start bit, 8 data bits MSB-first, and 1 stop bit. Each recovered byte is presented with a one-cycle valid strobe. The block sits between the board RX pin and the command parser.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_bps_cnt.sv | 38 +++
 rtl/uart_rx_ctrl.sv | 156 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t           receiver FSM state encoding
//   UART_DATA_BITS            payload bits per frame
//   UART_DEFAULT_CLKS_PER_BIT system clocks per bit (50 MHz / 115200)
//   maj3()                    2-of-3 majority vote, used by the
//                             UART_RX_MAJORITY_EN build of uart_rx_ctrl
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bps_cnt.sv
// uart_rx_bps_cnt: bit-period counter for the UART receiver.
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous clear (has priority over en)
//   en          count enable
//   tick_half   count == CLKS_PER_BIT/2 - 1  (start-bit sample point)
//   tick_total  count == CLKS_PER_BIT - 1    (data/stop sample point)
module uart_rx_bps_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick_half,
    output logic tick_total
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign tick_half  = (cnt == HALF_M1);
    assign tick_total = (cnt == FULL_M1);

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver (start, 8 data bits MSB-first, 1 stop).
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_in      asynchronous serial line, idles high
//   rx_data    last good byte (first received bit in rx_data[7])
//   rx_valid   one-cycle pulse when rx_data is updated
//   rx_busy    high from start-edge detection until return to IDLE
//   frame_err  one-cycle pulse when the stop bit is sampled low
// Build option: define UART_RX_MAJORITY_EN to take each sample as a
// 2-of-3 vote around the sample point; decisions then land one clock later.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    logic rx_m, rx_s, rx_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    uart_rx_state_t              state;
    logic [2:0]                  bit_idx;
    logic [UART_DATA_BITS-1:0]   shreg;
    logic                        tick_half, tick_total;
    logic                        sample_tick, cnt_clr, cnt_en;
    logic                        decide, sample_bit;
    logic                        start_edge;

    // A falling edge, not a low level, starts a frame.
    assign start_edge = rx_p & ~rx_s;

    always_comb begin
        sample_tick = 1'b0;
        case (state)
            START:      sample_tick = tick_half;
            DATA, STOP: sample_tick = tick_total;
            default:    sample_tick = 1'b0;
        endcase
    end

    // Restarting the count at every sample point keeps each bit measured
    // from the previous sample; IDLE holds the counter at zero.
    assign cnt_clr = (state == IDLE) || sample_tick;
    assign cnt_en  = (state != IDLE);

    uart_rx_bps_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bps_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .tick_half  (tick_half),
        .tick_total (tick_total)
    );

`ifdef UART_RX_MAJORITY_EN
    // The counter still restarts at the sample point, so bit spacing is
    // unchanged; only the decision is deferred one clock to see sp+1.
    logic rx_pp, decide_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_pp    <= 1'b1;
            decide_d <= 1'b0;
        end else begin
            rx_pp    <= rx_p;
            decide_d <= sample_tick;
        end
    end

    assign decide     = decide_d;
    assign sample_bit = maj3(rx_s, rx_p, rx_pp);
`else
    assign decide     = sample_tick;
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (decide) begin
                        if (!sample_bit) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg   <= {shreg[UART_DATA_BITS-2:0], sample_bit};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (decide) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                        if (sample_bit) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl at CLKS_PER_BIT=16.
// The pin waveform is built per clock as a queue; expected strobes, data
// and strobe cycles are derived from the frame timing rules.
// Honours UART_RX_MAJORITY_EN (adds one clock of latency, spike immunity).
module tb_uart_rx_ctrl;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Pin driven at negedge with cycle count c reaches rx_s at c+2 (start
    // edge cycle); strobe follows the stop sample by one clock.
    localparam int LAT = 2 + HALF + 9 * CPB + 1 + MAJ;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records observed strobes and busy activity.
    int         got_v_cyc[$];
    logic [7:0] got_v_dat[$];
    int         got_e_cyc[$];
    int         busy_starts = 0;
    int         busy_run = 0;
    int         last_busy_run = 0;
    bit         both_seen = 1'b0;
    logic       busy_q = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_v_cyc.push_back(cyc);
            got_v_dat.push_back(rx_data);
        end
        if (frame_err) got_e_cyc.push_back(cyc);
        if (rx_valid && frame_err) both_seen = 1'b1;
        if (rx_busy) begin
            if (!busy_q) busy_starts++;
            busy_run++;
        end else if (busy_q) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
        busy_q = rx_busy;
    end

    // Stimulus and reference model state.
    logic       wave[$];
    int         pend_off[$];
    bit         pend_good[$];
    logic [7:0] pend_dat[$];
    int         exp_v_cyc[$];
    logic [7:0] exp_v_dat[$];
    int         exp_e_cyc[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         errors = 0;

    task automatic add_level(input logic v, input int n);
        for (int i = 0; i < n; i++) wave.push_back(v);
    endtask

    task automatic add_frame(input logic [7:0] b, input logic stop_val, input int stop_len,
                             input logic [7:0] exp_dat, input bit expect_it, output int off);
        logic [7:0] t;
        off = wave.size();
        t = b;
        add_level(1'b0, CPB);
        for (int k = 7; k >= 0; k--) add_level(t[k], CPB);
        add_level(stop_val, stop_len);
        if (expect_it) begin
            pend_off.push_back(off);
            pend_good.push_back(stop_val == 1'b1);
            pend_dat.push_back(exp_dat);
        end
    endtask

    // Plays the first n pin samples (all if n < 0), one per clock.
    task automatic play(input int n);
        int base, lim;
        lim = (n < 0 || n > wave.size()) ? wave.size() : n;
        @(negedge clk);
        base = cyc;
        for (int i = 0; i < pend_off.size(); i++) begin
            if (pend_good[i]) begin
                exp_v_cyc.push_back(base + pend_off[i] + LAT);
                exp_v_dat.push_back(pend_dat[i]);
                last_good = pend_dat[i];
            end else begin
                exp_e_cyc.push_back(base + pend_off[i] + LAT);
            end
        end
        for (int i = 0; i < lim; i++) begin
            if (i > 0) @(negedge clk);
            rx_in = wave[i];
        end
        wave.delete();
        pend_off.delete();
        pend_good.delete();
        pend_dat.delete();
    endtask

    task automatic clear_exp();
        exp_v_cyc.delete();
        exp_v_dat.delete();
        exp_e_cyc.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs got data=%h v=%b b=%b fe=%b want 00/0/0/0",
                     rx_data, rx_valid, rx_busy, frame_err);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int off, gv0, ge0;
        clear_exp();
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size();
        add_level(1'b1, 4);
        add_frame(8'hA5, 1'b1, CPB, 8'hA5, 1'b1, off);
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 1 || got_e_cyc.size() - ge0 !== 0) begin
            errors++;
            $display("FAIL single_count got v=%0d fe=%0d want v=1 fe=0",
                     got_v_cyc.size() - gv0, got_e_cyc.size() - ge0);
        end else begin
            checks++;
            if (got_v_dat[gv0] !== 8'hA5 || got_v_cyc[gv0] !== exp_v_cyc[0]) begin
                errors++;
                $display("FAIL single_a5 got %h@%0d want a5@%0d", got_v_dat[gv0], got_v_cyc[gv0], exp_v_cyc[0]);
            end
        end
        checks++;
        if (rx_data !== 8'hA5 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_hold got data=%h busy=%b want a5/0", rx_data, rx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int off, gv0, ge0;
        clear_exp();
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size();
        add_frame(8'h00, 1'b1, HALF + 2, 8'h00, 1'b1, off);
        add_frame(8'hFF, 1'b1, HALF + 2, 8'hFF, 1'b1, off);
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 2 || got_e_cyc.size() - ge0 !== 0) begin
            errors++;
            $display("FAIL b2b_count got v=%0d fe=%0d want v=2 fe=0",
                     got_v_cyc.size() - gv0, got_e_cyc.size() - ge0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_v_dat[gv0+i] !== exp_v_dat[i] || got_v_cyc[gv0+i] !== exp_v_cyc[i]) begin
                    errors++;
                    $display("FAIL b2b_frame%0d got %h@%0d want %h@%0d", i,
                             got_v_dat[gv0+i], got_v_cyc[gv0+i], exp_v_dat[i], exp_v_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int gv0, ge0, bs0;
        logic [7:0] prev;
        prev = last_good;
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size(); bs0 = busy_starts;
        add_level(1'b0, 3);
        add_level(1'b1, 40);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 0 || got_e_cyc.size() - ge0 !== 0) begin
            errors++;
            $display("FAIL glitch_strobe got v=%0d fe=%0d want 0/0",
                     got_v_cyc.size() - gv0, got_e_cyc.size() - ge0);
        end
        checks++;
        if (busy_starts - bs0 !== 1 || last_busy_run !== HALF + MAJ) begin
            errors++;
            $display("FAIL glitch_busy got starts=%0d run=%0d want 1/%0d",
                     busy_starts - bs0, last_busy_run, HALF + MAJ);
        end
        checks++;
        if (rx_busy !== 1'b0 || rx_data !== prev) begin
            errors++;
            $display("FAIL glitch_idle got busy=%b data=%h want 0/%h", rx_busy, rx_data, prev);
        end
    endtask

    task automatic test_frame_err();
        int off, gv0, ge0, bs0;
        logic [7:0] prev;
        clear_exp();
        prev = last_good;
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size(); bs0 = busy_starts;
        add_level(1'b1, 5);
        add_frame(8'h3C, 1'b0, CPB + 40, 8'h00, 1'b1, off);
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_e_cyc.size() - ge0 !== 1 || got_v_cyc.size() - gv0 !== 0) begin
            errors++;
            $display("FAIL ferr_count got fe=%0d v=%0d want 1/0",
                     got_e_cyc.size() - ge0, got_v_cyc.size() - gv0);
        end else begin
            checks++;
            if (got_e_cyc[ge0] !== exp_e_cyc[0]) begin
                errors++;
                $display("FAIL ferr_cycle got %0d want %0d", got_e_cyc[ge0], exp_e_cyc[0]);
            end
        end
        checks++;
        if (rx_data !== prev || busy_starts - bs0 !== 1) begin
            errors++;
            $display("FAIL ferr_hold got data=%h starts=%0d want %h/1", rx_data, busy_starts - bs0, prev);
        end
        clear_exp();
        gv0 = got_v_cyc.size();
        add_frame(8'hC3, 1'b1, CPB, 8'hC3, 1'b1, off);
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 1) begin
            errors++;
            $display("FAIL ferr_recover_count got %0d want 1", got_v_cyc.size() - gv0);
        end else begin
            checks++;
            if (got_v_dat[gv0] !== 8'hC3 || got_v_cyc[gv0] !== exp_v_cyc[0]) begin
                errors++;
                $display("FAIL ferr_recover got %h@%0d want c3@%0d", got_v_dat[gv0], got_v_cyc[gv0], exp_v_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int off, gv0, ge0;
        clear_exp();
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size();
        add_frame(8'h81, 1'b1, CPB, 8'h81, 1'b0, off);
        play(5 * CPB + 5);
        @(negedge clk);
        rst = 1'b1;
        rx_in = 1'b1;
        #1;
        checks++;
        if ({rx_data, rx_valid, rx_busy, frame_err} !== 11'h000) begin
            errors++;
            $display("FAIL midreset_outputs got data=%h v=%b b=%b fe=%b want 00/0/0/0",
                     rx_data, rx_valid, rx_busy, frame_err);
        end
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (got_v_cyc.size() - gv0 !== 0 || got_e_cyc.size() - ge0 !== 0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_quiet got v=%0d fe=%0d busy=%b want 0/0/0",
                     got_v_cyc.size() - gv0, got_e_cyc.size() - ge0, rx_busy);
        end
        add_frame(8'h81, 1'b1, CPB, 8'h81, 1'b1, off);
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 1) begin
            errors++;
            $display("FAIL midreset_count got %0d want 1", got_v_cyc.size() - gv0);
        end else begin
            checks++;
            if (got_v_dat[gv0] !== 8'h81 || got_v_cyc[gv0] !== exp_v_cyc[0]) begin
                errors++;
                $display("FAIL midreset_frame got %h@%0d want 81@%0d", got_v_dat[gv0], got_v_cyc[gv0], exp_v_cyc[0]);
            end
        end
    endtask

    // One-clock inversion exactly at each data sample point: a single
    // sample reads every bit inverted, a majority vote rejects the spikes.
    task automatic test_spike();
        int off, gv0, idx;
        logic [7:0] want;
        clear_exp();
        gv0 = got_v_cyc.size();
        want = (MAJ == 1) ? 8'h5A : 8'hA5;
        add_level(1'b1, 3);
        add_frame(8'h5A, 1'b1, CPB, want, 1'b1, off);
        add_level(1'b1, 30);
        for (int k = 0; k < 8; k++) begin
            idx = off + HALF + (k + 1) * CPB;
            wave[idx] = ~wave[idx];
        end
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== 1) begin
            errors++;
            $display("FAIL spike_count got %0d want 1", got_v_cyc.size() - gv0);
        end else begin
            checks++;
            if (got_v_dat[gv0] !== want || got_v_cyc[gv0] !== exp_v_cyc[0]) begin
                errors++;
                $display("FAIL spike_frame got %h@%0d want %h@%0d", got_v_dat[gv0], got_v_cyc[gv0], want, exp_v_cyc[0]);
            end
        end
    endtask

    task automatic test_random();
        int off, gv0, ge0;
        logic [7:0] b;
        bit good;
        clear_exp();
        gv0 = got_v_cyc.size(); ge0 = got_e_cyc.size();
        add_level(1'b1, 2);
        for (int f = 0; f < 10; f++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if (good) begin
                add_frame(b, 1'b1, HALF + 2 + int'($urandom_range(0, CPB)), b, 1'b1, off);
                add_level(1'b1, int'($urandom_range(0, 10)));
            end else begin
                add_frame(b, 1'b0, CPB, b, 1'b1, off);
                add_level(1'b1, int'($urandom_range(1, 10)));
            end
        end
        add_level(1'b1, 30);
        play(-1);
        checks++;
        if (got_v_cyc.size() - gv0 !== exp_v_cyc.size() || got_e_cyc.size() - ge0 !== exp_e_cyc.size()) begin
            errors++;
            $display("FAIL rand_count got v=%0d fe=%0d want v=%0d fe=%0d", got_v_cyc.size() - gv0,
                     got_e_cyc.size() - ge0, exp_v_cyc.size(), exp_e_cyc.size());
        end else begin
            for (int i = 0; i < exp_v_cyc.size(); i++) begin
                checks++;
                if (got_v_dat[gv0+i] !== exp_v_dat[i] || got_v_cyc[gv0+i] !== exp_v_cyc[i]) begin
                    errors++;
                    $display("FAIL rand_valid%0d got %h@%0d want %h@%0d", i,
                             got_v_dat[gv0+i], got_v_cyc[gv0+i], exp_v_dat[i], exp_v_cyc[i]);
                end
            end
            for (int i = 0; i < exp_e_cyc.size(); i++) begin
                checks++;
                if (got_e_cyc[ge0+i] !== exp_e_cyc[i]) begin
                    errors++;
                    $display("FAIL rand_ferr%0d got %0d want %0d", i, got_e_cyc[ge0+i], exp_e_cyc[i]);
                end
            end
        end
        checks++;
        if (rx_data !== last_good) begin
            errors++;
            $display("FAIL rand_last_data got %h want %h", rx_data, last_good);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("FAIL strobe_exclusive got rx_valid&frame_err=1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_spike();
        test_random();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
